// File: rtl/branch_predictor_pkg.sv
// Shared types and constants for the fetch-side branch predictor.
package branch_predictor_pkg;

    localparam int unsigned WORD_LENGTH = 32;
    localparam int unsigned STAT_W      = 32;

    // 2-bit saturating direction counter; upper bit is the taken prediction
    typedef enum logic [1:0] {
        SNT = 2'b00,
        WNT = 2'b01,
        WT  = 2'b10,
        ST  = 2'b11
    } bp_ctr_t;

    localparam bp_ctr_t BP_CTR_RESET = WNT;
    localparam bp_ctr_t BP_CTR_ALLOC = WT;

    // Direction predicted by a counter state
    function automatic logic bp_ctr_taken(input bp_ctr_t c);
        return (c == WT) || (c == ST);
    endfunction

endpackage

// File: rtl/branch_predictor_sat_counter2.sv
// Next-state function of a 2-bit saturating up/down counter.
module sat_counter2
    import branch_predictor_pkg::*;
(
    input  bp_ctr_t ctr,
    input  logic    up,
    output bp_ctr_t next_ctr
);

    // Step one state toward taken or not-taken, holding at the ends
    always_comb begin
        next_ctr = ctr;
        case (ctr)
            SNT:     next_ctr = up ? WNT : SNT;
            WNT:     next_ctr = up ? WT  : SNT;
            WT:      next_ctr = up ? ST  : WNT;
            ST:      next_ctr = up ? ST  : WT;
            default: next_ctr = ctr;
        endcase
    end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with 2-bit counters: IF-stage lookup, EX-stage
// misprediction detection, redirect, training and statistics.
module branch_predictor
    import branch_predictor_pkg::*;
#(
    parameter int unsigned ENTRIES = 64
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [WORD_LENGTH-1:0] if_pc_i,
    output logic                   pred_taken_o,
    output logic [WORD_LENGTH-1:0] pred_target_o,
    output logic [WORD_LENGTH-1:0] pred_next_pc_o,
    input  logic                   ex_valid_i,
    input  logic [WORD_LENGTH-1:0] ex_pc_i,
    input  logic                   ex_taken_i,
    input  logic [WORD_LENGTH-1:0] ex_target_i,
    input  logic                   ex_pred_taken_i,
    input  logic [WORD_LENGTH-1:0] ex_pred_target_i,
    output logic                   mispredict_o,
    output logic [WORD_LENGTH-1:0] redirect_pc_o,
    output logic [STAT_W-1:0]      branch_cnt_o,
    output logic [STAT_W-1:0]      mispredict_cnt_o
);

    localparam int unsigned IDX_W = $clog2(ENTRIES);
    localparam int unsigned TAG_W = WORD_LENGTH - IDX_W - 2;
    localparam logic [WORD_LENGTH-1:0] PC_STEP = WORD_LENGTH'(4);
    localparam logic [STAT_W-1:0]      STAT_MAX = '1;
    localparam logic [STAT_W-1:0]      STAT_ONE = STAT_W'(1);

    // Table storage
    logic [ENTRIES-1:0]     valid_mem;
    logic [TAG_W-1:0]       tag_mem    [ENTRIES];
    logic [WORD_LENGTH-1:0] target_mem [ENTRIES];
    bp_ctr_t                ctr_mem    [ENTRIES];

    // Statistics
    logic [STAT_W-1:0] br_cnt;
    logic [STAT_W-1:0] mis_cnt;

    // Address split
    logic [IDX_W-1:0] if_idx;
    logic [TAG_W-1:0] if_tag;
    logic [IDX_W-1:0] ex_idx;
    logic [TAG_W-1:0] ex_tag;

    logic    if_hit;
    logic    ex_hit;
    bp_ctr_t ex_ctr_next;

    assign if_idx = if_pc_i[IDX_W+1:2];
    assign if_tag = if_pc_i[WORD_LENGTH-1:IDX_W+2];
    assign ex_idx = ex_pc_i[IDX_W+1:2];
    assign ex_tag = ex_pc_i[WORD_LENGTH-1:IDX_W+2];

    // Counter training step for the entry resolving in EX
    sat_counter2 u_sat_counter2 (
        .ctr      (ctr_mem[ex_idx]),
        .up       (ex_taken_i),
        .next_ctr (ex_ctr_next)
    );

    // Zero-latency lookup on the fetch PC; sees pre-update contents
    always_comb begin
        if_hit         = valid_mem[if_idx] && (tag_mem[if_idx] == if_tag);
        pred_taken_o   = !rst && if_hit && bp_ctr_taken(ctr_mem[if_idx]);
        pred_target_o  = if_hit ? target_mem[if_idx] : '0;
        pred_next_pc_o = pred_taken_o ? pred_target_o : (if_pc_i + PC_STEP);
    end

    // Misprediction detection and redirect for the branch in EX
    always_comb begin
        ex_hit        = valid_mem[ex_idx] && (tag_mem[ex_idx] == ex_tag);
        mispredict_o  = !rst && ex_valid_i &&
                        ((ex_taken_i != ex_pred_taken_i) ||
                         (ex_taken_i && ex_pred_taken_i &&
                          (ex_target_i != ex_pred_target_i)));
        redirect_pc_o = ex_taken_i ? ex_target_i : (ex_pc_i + PC_STEP);
    end

    // Table training: update on hit, allocate on taken miss
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_mem <= '0;
            for (int unsigned i = 0; i < ENTRIES; i++) begin
                tag_mem[i]    <= '0;
                target_mem[i] <= '0;
                ctr_mem[i]    <= BP_CTR_RESET;
            end
        end else if (ex_valid_i) begin
            if (ex_hit) begin
                ctr_mem[ex_idx] <= ex_ctr_next;
                if (ex_taken_i) begin
                    target_mem[ex_idx] <= ex_target_i;
                end
            end else if (ex_taken_i) begin
                valid_mem[ex_idx]  <= 1'b1;
                tag_mem[ex_idx]    <= ex_tag;
                target_mem[ex_idx] <= ex_target_i;
                ctr_mem[ex_idx]    <= BP_CTR_ALLOC;
            end
        end
    end

    // Saturating branch and mispredict statistics
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            br_cnt  <= '0;
            mis_cnt <= '0;
        end else begin
            if (ex_valid_i && (br_cnt != STAT_MAX)) begin
                br_cnt <= br_cnt + STAT_ONE;
            end
            if (mispredict_o && (mis_cnt != STAT_MAX)) begin
                mis_cnt <= mis_cnt + STAT_ONE;
            end
        end
    end

    assign branch_cnt_o     = br_cnt;
    assign mispredict_cnt_o = mis_cnt;

endmodule

// File: tb/tb_branch_predictor.sv
// Directed bench for branch_predictor with a table-level reference model.
module tb_branch_predictor;
    import branch_predictor_pkg::*;

    localparam int ENTRIES = 64;
    localparam int SH      = $clog2(ENTRIES) + 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] if_pc = 32'h100;
    logic        pred_taken;
    logic [31:0] pred_target, pred_next_pc;
    logic        ex_valid = 1'b0;
    logic [31:0] ex_pc = '0;
    logic        ex_taken = 1'b0;
    logic [31:0] ex_target = '0;
    logic        ex_pred_taken = 1'b0;
    logic [31:0] ex_pred_target = '0;
    logic        mispredict;
    logic [31:0] redirect_pc, branch_cnt, mispredict_cnt;

    int errors = 0;
    int checks = 0;

    // Reference model: one slot per index holding the full branch PC
    bit          m_valid [ENTRIES];
    logic [31:0] m_pc    [ENTRIES];
    logic [31:0] m_tgt   [ENTRIES];
    int          m_ctr   [ENTRIES];
    logic [31:0] m_bcnt, m_mcnt;

    branch_predictor #(.ENTRIES(ENTRIES)) dut (
        .clk              (clk),
        .rst              (rst),
        .if_pc_i          (if_pc),
        .pred_taken_o     (pred_taken),
        .pred_target_o    (pred_target),
        .pred_next_pc_o   (pred_next_pc),
        .ex_valid_i       (ex_valid),
        .ex_pc_i          (ex_pc),
        .ex_taken_i       (ex_taken),
        .ex_target_i      (ex_target),
        .ex_pred_taken_i  (ex_pred_taken),
        .ex_pred_target_i (ex_pred_target),
        .mispredict_o     (mispredict),
        .redirect_pc_o    (redirect_pc),
        .branch_cnt_o     (branch_cnt),
        .mispredict_cnt_o (mispredict_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Every negedge: compare against the model, then advance the model
    // to what the table must hold after the coming rising edge.
    always @(negedge clk) begin : model_cmp
        int          idx;
        bit          hit, e_pt, e_mis;
        logic [31:0] e_tgt, e_next, e_red;
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                m_valid[i] = 1'b0;
                m_ctr[i]   = 1;
            end
            m_bcnt = '0;
            m_mcnt = '0;
        end
        idx    = int'((if_pc >> 2) % ENTRIES);
        hit    = m_valid[idx] && ((m_pc[idx] >> SH) == (if_pc >> SH));
        e_pt   = !rst && hit && (m_ctr[idx] >= 2);
        e_tgt  = hit ? m_tgt[idx] : 32'h0;
        e_next = e_pt ? e_tgt : if_pc + 32'd4;
        e_mis  = !rst && ex_valid && ((ex_taken != ex_pred_taken) ||
                 (ex_taken && ex_target != ex_pred_target));
        e_red  = ex_taken ? ex_target : ex_pc + 32'd4;
        chk("model pred_taken", 32'(pred_taken), 32'(e_pt));
        chk("model pred_target", pred_target, e_tgt);
        chk("model pred_next_pc", pred_next_pc, e_next);
        chk("model mispredict", 32'(mispredict), 32'(e_mis));
        if (e_mis) chk("model redirect_pc", redirect_pc, e_red);
        chk("model branch_cnt", branch_cnt, m_bcnt);
        chk("model mispredict_cnt", mispredict_cnt, m_mcnt);
        if (!rst && ex_valid) begin
            idx = int'((ex_pc >> 2) % ENTRIES);
            hit = m_valid[idx] && ((m_pc[idx] >> SH) == (ex_pc >> SH));
            if (hit) begin
                if (ex_taken) begin
                    m_ctr[idx] = (m_ctr[idx] == 3) ? 3 : m_ctr[idx] + 1;
                    m_tgt[idx] = ex_target;
                end else begin
                    m_ctr[idx] = (m_ctr[idx] == 0) ? 0 : m_ctr[idx] - 1;
                end
            end else if (ex_taken) begin
                m_valid[idx] = 1'b1;
                m_pc[idx]    = ex_pc;
                m_tgt[idx]   = ex_target;
                m_ctr[idx]   = 2;
            end
            if (m_bcnt != 32'hFFFF_FFFF) m_bcnt = m_bcnt + 32'd1;
            if (e_mis && m_mcnt != 32'hFFFF_FFFF) m_mcnt = m_mcnt + 32'd1;
        end
    end

    // Apply one cycle of inputs just after the rising edge
    task automatic drive(input logic [31:0] ipc, input logic v, input logic [31:0] epc,
                         input logic t, input logic [31:0] tgt,
                         input logic pt, input logic [31:0] ptg);
        @(posedge clk);
        #1;
        if_pc = ipc; ex_valid = v; ex_pc = epc; ex_taken = t;
        ex_target = tgt; ex_pred_taken = pt; ex_pred_target = ptg;
        #2;
    endtask

    task automatic idle(input logic [31:0] ipc);
        drive(ipc, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
    endtask

    initial begin
        // Reset state
        idle(32'h100);
        chk("reset pred_taken", 32'(pred_taken), 32'h0);
        chk("reset next_pc", pred_next_pc, 32'h104);
        chk("reset mispredict", 32'(mispredict), 32'h0);
        chk("reset branch_cnt", branch_cnt, 32'h0);
        rst = 1'b0;

        // Cold taken branch: mispredict and allocate
        drive(32'h100, 1'b1, 32'h100, 1'b1, 32'h80, 1'b0, 32'h0);
        chk("cold mispredict", 32'(mispredict), 32'h1);
        chk("cold redirect", redirect_pc, 32'h80);
        idle(32'h100);
        chk("alloc pred_taken", 32'(pred_taken), 32'h1);
        chk("alloc pred_target", pred_target, 32'h80);

        // Train T,T then NT,NT
        drive(32'h100, 1'b1, 32'h100, 1'b1, 32'h80, 1'b1, 32'h80);
        chk("correct T no mispredict", 32'(mispredict), 32'h0);
        drive(32'h0, 1'b1, 32'h100, 1'b1, 32'h80, 1'b1, 32'h80);
        drive(32'h0, 1'b1, 32'h100, 1'b0, 32'h80, 1'b1, 32'h80);
        chk("NT mispredict", 32'(mispredict), 32'h1);
        chk("NT redirect", redirect_pc, 32'h104);
        idle(32'h100);
        chk("after one NT pred_taken", 32'(pred_taken), 32'h1);
        chk("after one NT target", pred_target, 32'h80);
        drive(32'h0, 1'b1, 32'h100, 1'b0, 32'h80, 1'b1, 32'h80);
        idle(32'h100);
        chk("after two NT pred_taken", 32'(pred_taken), 32'h0);
        chk("after two NT next_pc", pred_next_pc, 32'h104);

        // Right direction, wrong target; lookup sees old target same cycle
        drive(32'h0, 1'b1, 32'h100, 1'b1, 32'h80, 1'b0, 32'h0);
        drive(32'h100, 1'b1, 32'h100, 1'b1, 32'h90, 1'b1, 32'h80);
        chk("target mispredict", 32'(mispredict), 32'h1);
        chk("target redirect", redirect_pc, 32'h90);
        chk("same-cycle old target", pred_target, 32'h80);
        idle(32'h100);
        chk("updated target", pred_target, 32'h90);

        // Alias at the same index replaces the entry
        idle(32'h100 + ENTRIES * 4);
        chk("alias miss", 32'(pred_taken), 32'h0);
        drive(32'h0, 1'b1, 32'h100 + ENTRIES * 4, 1'b1, 32'h200, 1'b0, 32'h0);
        idle(32'h100);
        chk("replaced entry misses", 32'(pred_taken), 32'h0);
        idle(32'h100 + ENTRIES * 4);
        chk("alias hit target", pred_target, 32'h200);

        // PC+4 wraps
        drive(32'hFFFF_FFFC, 1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0, 1'b1, 32'h40);
        chk("wrap next_pc", pred_next_pc, 32'h0);
        chk("wrap redirect", redirect_pc, 32'h0);

        // Stalled EX never mispredicts
        drive(32'h0, 1'b0, 32'h100, 1'b1, 32'h80, 1'b0, 32'h0);
        chk("invalid ex no mispredict", 32'(mispredict), 32'h0);

        // Train several entries, then reset mid-operation
        drive(32'h0, 1'b1, 32'h10, 1'b1, 32'h300, 1'b0, 32'h0);
        drive(32'h0, 1'b1, 32'h14, 1'b1, 32'h304, 1'b0, 32'h0);
        drive(32'h10, 1'b1, 32'h18, 1'b1, 32'h308, 1'b0, 32'h0);
        chk("trained before reset", 32'(pred_taken), 32'h1);
        rst = 1'b1;
        #1;
        chk("mid reset pred_taken", 32'(pred_taken), 32'h0);
        chk("mid reset mispredict", 32'(mispredict), 32'h0);
        idle(32'h14);
        rst = 1'b0;
        #1;
        chk("post reset miss", 32'(pred_taken), 32'h0);
        chk("post reset branch_cnt", branch_cnt, 32'h0);
        idle(32'h18);
        chk("post reset miss 2", 32'(pred_taken), 32'h0);

        // Mispredict counter saturation
        idle(32'h0);
        force dut.mis_cnt = 32'hFFFF_FFFE;
        m_mcnt = 32'hFFFF_FFFE;
        @(negedge clk);
        #1;
        release dut.mis_cnt;
        drive(32'h0, 1'b1, 32'h40, 1'b1, 32'h80, 1'b0, 32'h0);
        drive(32'h0, 1'b1, 32'h44, 1'b1, 32'h80, 1'b0, 32'h0);
        drive(32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
        chk("mispredict_cnt saturated", mispredict_cnt, 32'hFFFF_FFFF);
        idle(32'h0);

        @(negedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/branch_predictor.md
Name: branch_predictor

Overview:
Fetch-side branch predictor paired with the EX-stage branch decision logic of the RV32I 5-stage pipeline. In IF it predicts the direction and target of the instruction at the current PC using a direct-mapped branch target buffer (BTB) with 2-bit saturating counters. In EX it consumes the resolved outcome (taken flag, actual target), detects mispredictions, supplies the redirect PC and trains the table. It also keeps branch and mispredict statistics counters.

Parameters:
ENTRIES, 64, BTB entry count; power of two, >= 2
IDX_W, $clog2(ENTRIES), index width (derived; not overridden)
TAG_W, WORD_LENGTH-IDX_W-2, tag width (derived)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-high reset
if_pc_i  in  WORD_LENGTH  PC being fetched
pred_taken_o  out  1  predicted taken for if_pc_i
pred_target_o  out  WORD_LENGTH  predicted target (valid when pred_taken_o=1)
pred_next_pc_o  out  WORD_LENGTH  pred_taken_o ? pred_target_o : if_pc_i+4
ex_valid_i  in  1  conditional branch resolving in EX this cycle (deasserted while EX is stalled or flushed)
ex_pc_i  in  WORD_LENGTH  PC of the resolving branch
ex_taken_i  in  1  resolved direction from branch decision logic
ex_target_i  in  WORD_LENGTH  computed branch target
ex_pred_taken_i  in  1  prediction carried down the pipe with this branch
ex_pred_target_i  in  WORD_LENGTH  predicted target carried down the pipe
mispredict_o  out  1  flush IF/ID and redirect this cycle
redirect_pc_o  out  WORD_LENGTH  correct next PC
branch_cnt_o  out  32  resolved branches, saturating
mispredict_cnt_o  out  32  mispredictions, saturating

Behaviour:
- Index = pc[IDX_W+1:2], tag = pc[WORD_LENGTH-1:IDX_W+2]; pc[1:0] ignored.
- Entry fields: valid, tag, target, ctr[1:0] (00 strong NT, 01 weak NT, 10 weak T, 11 strong T).
- Reset (async): all valid=0, all ctr=01, both stat counters=0. Outputs during reset: pred_taken_o=0, mispredict_o=0, pred_next_pc_o=if_pc_i+4.
- Lookup is combinational, zero latency: hit = valid & tag match; pred_taken_o = hit & ctr[1]; pred_target_o = entry target on hit, else 0.
- Misprediction is combinational in EX: mispredict_o = ex_valid_i & ((ex_taken_i != ex_pred_taken_i) | (ex_taken_i & ex_pred_taken_i & ex_target_i != ex_pred_target_i)).
- redirect_pc_o = ex_taken_i ? ex_target_i : ex_pc_i+4; meaningful only when mispredict_o=1.
- Update at the rising edge when ex_valid_i=1:
  hit: ctr saturating +1 if taken, -1 if not; on taken, target <= ex_target_i.
  miss & taken: allocate/overwrite: valid=1, tag, target, ctr=10.
  miss & not taken: no change.
- Same-cycle lookup and update of the same index: the lookup sees the pre-update contents (no bypass).
- Stats: branch_cnt_o +1 per ex_valid_i cycle; mispredict_cnt_o +1 per mispredict_o cycle; both hold at 32'hFFFF_FFFF.
- PC+4 wraps modulo 2^WORD_LENGTH.
- Reset asserted mid-operation clears all state immediately; the first cycle after deassertion behaves as an empty table.

Decomposition:
- RISCV_PKG: WORD_LENGTH (existing); add bp_ctr_t (2-bit enum: SNT/WNT/WT/ST), BP_CTR_RESET=WNT, BP_CTR_ALLOC=WT.
- Sub-module sat_counter2: 2-bit saturating up/down counter with next-state function, instantiated per entry or used as a function on the indexed entry.

Test Plan:
- Reset, then if_pc_i=0x100 -> pred_taken_o=0, pred_next_pc_o=0x104, counters 0.
- ex_valid_i=1, pc=0x100, taken=1, target=0x80, pred_taken=0 -> mispredict_o=1, redirect_pc_o=0x80. Next cycle, lookup 0x100 -> pred_taken_o=1, pred_target_o=0x80.
- Same branch resolved T,T (ctr 11), then NT -> ctr 10, lookup still taken, no target change. A second NT -> ctr 01 and lookup predicts not-taken. An NT mispredict gives redirect_pc_o=0x104.
- Alias: train 0x100 taken, then lookup 0x100+ENTRIES*4 -> miss, pred_taken_o=0. Resolve it taken with target 0x200 -> entry replaced, and 0x100 now misses.
- Correct direction with wrong target (pred 0x80, actual 0x90) -> mispredict_o=1, redirect 0x90, entry target updated. Same-cycle lookup of 0x100 still returns 0x80.
- Train several entries, assert rst mid-cycle -> next lookups all miss, stats=0. Force mispredict_cnt to saturate -> stays 0xFFFFFFFF.
